uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter core that serializes bytes onto the TX line in 8N1 format (1 start LOW, DATA_WIDTH data bits LSB first, 1 stop HIGH). Timing is driven by the shared 16× baud sample_tick, so each bit lasts exactly OVERSAMPLE_RATE ticks. A one-entry holding register is accepted through a valid/ready handshake and allows back-to-back frames with no idle gap. It sits beside the receiver core in the UART top level, and its line output loops back to the receiver input in loopback tests.

Parameters:
DATA_WIDTH, 8, data bits per frame
OVERSAMPLE_RATE, 16, sample_ticks per bit period

Ports:
uart_clk  input  1  core clock
rst_n  input  1  asynchronous, active-low reset
sample_tick  input  1  single-cycle enable at 16× baud rate
tx_data  input  DATA_WIDTH  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  holding register empty; a transfer occurs when tx_valid && tx_ready on a uart_clk edge
tx_serial  output  1  serial line, registered, idle HIGH
tx_active  output  1  HIGH while state != IDLE
tx_done  output  1  one uart_clk pulse when a stop bit completes

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - tx_serial=1, tx_ready=1, tx_active=0, tx_done=0.
  - state=IDLE; holding register empty; all counters 0.
  - A frame interrupted by reset is abandoned; the line returns HIGH immediately.
- Handshake:
  - Evaluated on every uart_clk edge; not gated by sample_tick.
  - tx_ready = !hold_full.
  - On transfer, hold_reg<=tx_data and hold_full<=1.
  - tx_data may change freely after transfer.
  - tx_valid held with tx_ready low: data is stalled, not dropped.
- State machine (IDLE, START_BIT, DATA_BITS, STOP_BIT). All state, counter and line updates occur only on sample_tick:
  - IDLE:
    - If hold_full: state<=START_BIT, tx_serial<=0, shift_reg<=hold_reg, hold_full<=0, sample_counter<=0, bit_counter<=0.
    - Else: tx_serial stays 1.
  - START_BIT:
    - sample_counter increments each tick.
    - At OVERSAMPLE_RATE-1: counter<=0, state<=DATA_BITS, tx_serial<=shift_reg[0].
  - DATA_BITS:
    - At counter OVERSAMPLE_RATE-1: shift_reg shifts right by one.
    - If bit_counter==DATA_WIDTH-1: state<=STOP_BIT, tx_serial<=1.
    - Else: bit_counter++ and tx_serial<=next LSB.
  - STOP_BIT: at counter OVERSAMPLE_RATE-1, tx_done pulses for 1 uart_clk.
    - If hold_full: behave as IDLE-with-data in the same tick (next start bit begins immediately, no idle bit).
    - Else: state<=IDLE.
  - Illegal state encoding: return to IDLE, tx_serial<=1.
- Timing and latency:
  - Every bit is exactly OVERSAMPLE_RATE sample_ticks.
  - A frame is exactly (DATA_WIDTH+2)*OVERSAMPLE_RATE ticks (160 with defaults).
  - Start-bit latency from IDLE: the first sample_tick after hold_full=1.
  - tx_serial changes only on uart_clk edges where sample_tick=1. It is glitch-free (flop output).
- Boundary cases:
  - A transfer in the same cycle as the IDLE→START load: the load uses the old hold_reg. hold_full ends at 1 (new byte captured), and the old byte is not lost.
  - hold_full is cleared by the load and set by a new transfer in the same cycle: the set wins.
  - tx_ready may rise mid-frame. Only one byte is queued beyond the one on the line.
- Width rules:
  - sample_counter is $clog2(OVERSAMPLE_RATE) bits.
  - bit_counter is $clog2(DATA_WIDTH) bits.
  - Comparisons use explicitly sized constants.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum (logic [1:0]: IDLE, START_BIT, DATA_BITS, STOP_BIT).
  - UART_DATA_WIDTH=8.
  - UART_OVERSAMPLE=16.
  - Constants for line idle level (1) and start level (0).
- No sub-module. The holding register, FSM and shifter are one module; baud/tick generation lives outside.

Test Plan:
- Send 0x55 with a continuous tick every 4 clocks. Sample tx_serial at each bit center (tick 8 of 16). Required sequence: 0,1,0,1,0,1,0,1,0,1. tx_done pulses once, 160 ticks after the start edge.
- Send 0xA5 then 0x3C back-to-back, with tx_valid held high. The second start bit begins exactly 160 ticks after the first. No HIGH idle tick occurs between the stop bit and the start bit. tx_ready drops after the second accept and rises when 0x3C is loaded.
- Hold tx_valid with 3 bytes (0x01, 0x02, 0x03) while a frame is in flight. tx_ready=0 while the holding register is full. All three bytes appear in order; none is dropped.
- Assert rst_n=0 mid-DATA_BITS while sending 0xFF. tx_serial=1, tx_active=0 and tx_ready=1 immediately. A subsequent send of 0x81 is transmitted correctly.
- Loopback into the receiver core with bytes 0x00, 0xFF, 0x80. The receiver reports identical bytes with frame_error=0.
- Drive an irregular sample_tick (gaps of 1–7 clocks). The bit duration counts ticks, not clocks. Decoded bits are still correct for 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmitter and receiver cores.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Serial line levels
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1 serializer
// paced by the shared oversampled baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = UART_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE_RATE = UART_OVERSAMPLE
) (
  input  logic                  uart_clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_active,
  output logic                  tx_done
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

  tx_state_t             state_q,      state_d;
  logic [CNT_W-1:0]      sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic [DATA_WIDTH-1:0] hold_q,       hold_d;
  logic                  ready_d;
  logic                  serial_d;
  logic                  active_d;
  logic                  done_d;
  logic                  hold_full;
  logic                  load;

  // tx_ready is the registered "holding register empty" flag
  assign hold_full = !tx_ready;

  // State, datapath and registered outputs
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sample_cnt_q <= CNT_ZERO;
      bit_cnt_q    <= BIT_ZERO;
      shift_q      <= '0;
      hold_q       <= '0;
      tx_ready     <= 1'b1;
      tx_serial    <= LINE_IDLE;
      tx_active    <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      tx_ready     <= ready_d;
      tx_serial    <= serial_d;
      tx_active    <= active_d;
      tx_done      <= done_d;
    end
  end

  // Next-state: FSM advances on sample_tick, handshake on every clock
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    ready_d      = tx_ready;
    serial_d     = tx_serial;
    done_d       = 1'b0;
    load         = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          serial_d = LINE_IDLE;
          load     = hold_full;
        end
        START_BIT: begin
          if (sample_cnt_q == CNT_LAST) begin
            sample_cnt_d = CNT_ZERO;
            state_d      = DATA_BITS;
            serial_d     = shift_q[0];
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
          end
        end
        DATA_BITS: begin
          if (sample_cnt_q == CNT_LAST) begin
            sample_cnt_d = CNT_ZERO;
            shift_d      = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d  = STOP_BIT;
              serial_d = LINE_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_ONE;
              serial_d  = shift_d[0];
            end
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
          end
        end
        STOP_BIT: begin
          if (sample_cnt_q == CNT_LAST) begin
            sample_cnt_d = CNT_ZERO;
            done_d       = 1'b1;
            // A queued byte starts its start bit with no idle gap
            if (hold_full) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + CNT_ONE;
          end
        end
        default: begin
          // Illegal encoding recovers to an idle line
          state_d      = IDLE;
          serial_d     = LINE_IDLE;
          sample_cnt_d = CNT_ZERO;
          bit_cnt_d    = BIT_ZERO;
        end
      endcase

      if (load) begin
        state_d      = START_BIT;
        serial_d     = LINE_START;
        shift_d      = hold_q;
        ready_d      = 1'b1;
        sample_cnt_d = CNT_ZERO;
        bit_cnt_d    = BIT_ZERO;
      end
    end

    // A new transfer overrides the load's clear of the holding register
    if (tx_valid && tx_ready) begin
      hold_d  = tx_data;
      ready_d = 1'b0;
    end

    active_d = (state_d != IDLE);
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx with a tick-counting line decoder.
module tb_uart_tx;

  logic       uart_clk = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  int checks   = 0;
  int failures = 0;

  int tick_count = 0;
  bit irregular  = 1'b0;

  logic [7:0] rx_bytes[$];
  bit         rx_err[$];
  logic [9:0] rx_bits[$];
  int         starts[$];
  int         dones[$];

  bit         rx_busy   = 1'b0;
  int         rx_start  = 0;
  int         last_tick = 0;
  logic [9:0] rx_vec    = '0;

  uart_tx dut (
    .uart_clk   (uart_clk),
    .rst_n      (rst_n),
    .sample_tick(sample_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .tx_active  (tx_active),
    .tx_done    (tx_done)
  );

  always #5 uart_clk = ~uart_clk;

  // Tick source: every 4 clocks, or random gaps of 1..7 clocks
  initial begin
    int gap;
    gap = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge uart_clk);
      if (gap == 0) begin
        sample_tick = 1'b1;
        gap = irregular ? int'($urandom_range(6, 0)) : 3;
      end else begin
        sample_tick = 1'b0;
        gap = gap - 1;
      end
    end
  end

  always @(posedge uart_clk) begin
    if (sample_tick) tick_count <= tick_count + 1;
  end

  // Line decoder: counts ticks from the start edge, samples at bit centres
  always @(negedge uart_clk) begin
    int rel;
    int j;
    if (!rst_n) begin
      rx_busy   = 1'b0;
      last_tick = tick_count;
    end else begin
      if (tx_done === 1'b1) dones.push_back(tick_count);
      if (tick_count != last_tick) begin
        last_tick = tick_count;
        if (!rx_busy) begin
          if (tx_serial === 1'b0) begin
            rx_busy  = 1'b1;
            rx_start = tick_count;
            starts.push_back(tick_count);
          end
        end else begin
          rel = tick_count - rx_start;
          if (rel % 16 == 8) begin
            j = rel / 16;
            rx_vec[j] = tx_serial;
            if (j == 9) begin
              rx_bits.push_back(rx_vec);
              rx_bytes.push_back(rx_vec[8:1]);
              rx_err.push_back(rx_vec[0] !== 1'b0 || rx_vec[9] !== 1'b1);
              rx_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic clear_log();
    rx_bytes.delete();
    rx_err.delete();
    rx_bits.delete();
    starts.delete();
    dones.delete();
  endtask

  // Offer a byte from a negedge; returns at the negedge after the transfer
  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (tx_ready === 1'b1) begin
        @(negedge uart_clk);
        ok = 1'b1;
        break;
      end
      @(negedge uart_clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_accept got=timeout exp=accept of %0h", d);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 4000 * n; i++) begin
      if (rx_bytes.size() >= n && dones.size() >= n) break;
      @(negedge uart_clk);
    end
    repeat (4) @(negedge uart_clk);
    checks++;
    if (rx_bytes.size() != n || dones.size() != n) begin
      failures++;
      $display("FAIL frame_count got=%0d/%0d exp=%0d", rx_bytes.size(), dones.size(), n);
    end
  endtask

  task automatic test_reset();
    checks += 4;
    if (tx_serial !== 1'b1) begin failures++; $display("FAIL rst_serial got=%b exp=1", tx_serial); end
    if (tx_ready  !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", tx_ready); end
    if (tx_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", tx_active); end
    if (tx_done   !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", tx_done); end
    rst_n = 1'b1;
    repeat (4) @(negedge uart_clk);
  endtask

  task automatic test_single_55();
    clear_log();
    send(8'h55);
    tx_valid = 1'b0;
    repeat (8) @(negedge uart_clk);
    checks += 3;
    if (tx_active !== 1'b1) begin failures++; $display("FAIL s55_active got=%b exp=1", tx_active); end
    if (tx_ready  !== 1'b1) begin failures++; $display("FAIL s55_ready got=%b exp=1", tx_ready); end
    if (tx_serial !== 1'b0) begin failures++; $display("FAIL s55_start got=%b exp=0", tx_serial); end
    wait_frames(1);
    checks += 4;
    if (rx_bits[0] !== 10'b1010101010) begin
      failures++; $display("FAIL s55_bits got=%b exp=1010101010", rx_bits[0]);
    end
    if (dones[0] - starts[0] != 160) begin
      failures++; $display("FAIL s55_done_ticks got=%0d exp=160", dones[0] - starts[0]);
    end
    if (tx_active !== 1'b0) begin failures++; $display("FAIL s55_idle_active got=%b exp=0", tx_active); end
    if (tx_serial !== 1'b1) begin failures++; $display("FAIL s55_idle_serial got=%b exp=1", tx_serial); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    clear_log();
    send(8'hA5);
    send(8'h3C);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low got=%b exp=0", tx_ready); end
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready === 1'b1) begin seen = 1'b1; break; end
      @(negedge uart_clk);
    end
    checks += 4;
    if (!seen) begin failures++; $display("FAIL b2b_ready_rise got=timeout exp=rise"); end
    if (tick_count != starts[0] + 160) begin
      failures++; $display("FAIL b2b_load_tick got=%0d exp=%0d", tick_count, starts[0] + 160);
    end
    if (tx_serial !== 1'b0) begin failures++; $display("FAIL b2b_next_start got=%b exp=0", tx_serial); end
    if (tx_done !== 1'b1) begin failures++; $display("FAIL b2b_done_at_load got=%b exp=1", tx_done); end
    wait_frames(2);
    checks += 3;
    if (rx_bytes[0] !== 8'hA5 || rx_err[0]) begin
      failures++; $display("FAIL b2b_byte0 got=%h err=%b exp=a5", rx_bytes[0], rx_err[0]);
    end
    if (rx_bytes[1] !== 8'h3C || rx_err[1]) begin
      failures++; $display("FAIL b2b_byte1 got=%h err=%b exp=3c", rx_bytes[1], rx_err[1]);
    end
    if (starts[1] - starts[0] != 160) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=160", starts[1] - starts[0]);
    end
  endtask

  task automatic test_hold_three();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
    clear_log();
    send(8'h01);
    send(8'h02);
    checks += 2;
    if (tx_ready  !== 1'b0) begin failures++; $display("FAIL h3_ready_full got=%b exp=0", tx_ready); end
    if (tx_active !== 1'b1) begin failures++; $display("FAIL h3_active got=%b exp=1", tx_active); end
    tx_data = 8'h03;
    repeat (100) @(negedge uart_clk);
    checks++;
    if (tx_ready !== 1'b0) begin failures++; $display("FAIL h3_stall_ready got=%b exp=0", tx_ready); end
    send(8'h03);
    tx_valid = 1'b0;
    wait_frames(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_b[k] || rx_err[k]) begin
        failures++; $display("FAIL h3_byte%0d got=%h err=%b exp=%h", k, rx_bytes[k], rx_err[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit reached;
    clear_log();
    send(8'hFF);
    send(8'h7E);
    tx_valid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (starts.size() >= 1 && tick_count >= starts[0] + 40) begin reached = 1'b1; break; end
      @(negedge uart_clk);
    end
    checks += 2;
    if (!reached) begin failures++; $display("FAIL rm_reach got=timeout exp=data_bits"); end
    if (tx_active !== 1'b1) begin failures++; $display("FAIL rm_active_pre got=%b exp=1", tx_active); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (tx_serial !== 1'b1) begin failures++; $display("FAIL rm_serial got=%b exp=1", tx_serial); end
    if (tx_active !== 1'b0) begin failures++; $display("FAIL rm_active got=%b exp=0", tx_active); end
    if (tx_ready  !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", tx_ready); end
    repeat (3) @(negedge uart_clk);
    clear_log();
    rst_n = 1'b1;
    repeat (2) @(negedge uart_clk);
    send(8'h81);
    tx_valid = 1'b0;
    wait_frames(1);
    repeat (800) @(negedge uart_clk);
    checks += 2;
    if (rx_bytes[0] !== 8'h81 || rx_err[0]) begin
      failures++; $display("FAIL rm_after got=%h err=%b exp=81", rx_bytes[0], rx_err[0]);
    end
    if (rx_bytes.size() != 1) begin
      failures++; $display("FAIL rm_stale_frames got=%0d exp=1", rx_bytes.size());
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b[3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h80;
    clear_log();
    for (int k = 0; k < 3; k++) send(exp_b[k]);
    tx_valid = 1'b0;
    wait_frames(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_b[k] || rx_err[k]) begin
        failures++; $display("FAIL lb_byte%0d got=%h err=%b exp=%h", k, rx_bytes[k], rx_err[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_irregular();
    irregular = 1'b1;
    clear_log();
    send(8'hC3);
    tx_valid = 1'b0;
    wait_frames(1);
    checks += 2;
    if (rx_bits[0] !== 10'b1110000110 || rx_err[0]) begin
      failures++; $display("FAIL irr_bits got=%b err=%b exp=1110000110", rx_bits[0], rx_err[0]);
    end
    if (dones[0] - starts[0] != 160) begin
      failures++; $display("FAIL irr_done_ticks got=%0d exp=160", dones[0] - starts[0]);
    end
    irregular = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge uart_clk);
    test_reset();
    test_single_55();
    test_back_to_back();
    test_hold_three();
    test_reset_mid();
    test_loopback();
    test_irregular();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx
